// File: rtl/axi_stream_pkt_checker.sv
// AXI4-Stream sink that checks incrementing-count packets (payload, TDEST, TID, length)
// and reports per-packet pass/fail, with optional LFSR-driven backpressure.
//
// state  | meaning
// IDLE   | waiting for the first beat of a packet
// RECV   | mid-packet, accepting beats until TLAST
// REPORT | one-cycle result pulse; TREADY held low
module axi_stream_pkt_checker #(
  parameter int STREAM_DATA_WIDTH = 32,
  parameter int STREAM_ID_WIDTH   = 2,
  parameter int CNT_WIDTH         = 24,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [STREAM_DATA_WIDTH-1:0] TDATA,
  input  logic                         TLAST,
  input  logic [STREAM_ID_WIDTH-1:0]   TID,
  input  logic [1:0]                   TDEST,
  input  logic                         TVALID,
  output logic                         TREADY,
  input  logic [CNT_WIDTH-1:0]         cfg_expected_beats,
  input  logic [1:0]                   cfg_dest,
  input  logic                         cfg_stall_en,
  input  logic                         cfg_clear,
  output logic                         pkt_done,
  output logic                         pkt_ok,
  output logic [CNT_WIDTH-1:0]         last_len,
  output logic [15:0]                  pkt_count,
  output logic [15:0]                  err_count,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  state_t                       state, next_state;
  logic [15:0]                  lfsr;
  logic                         lfsr_fb;
  logic [CNT_WIDTH-1:0]         beat_cnt;
  logic [CNT_WIDTH-1:0]         len_sat;
  logic [STREAM_DATA_WIDTH-1:0] exp_data;
  logic                         err;
  logic                         beat;
  logic                         beat_err;
  logic                         len_err;
  logic                         pkt_fail;

  assign beat    = TVALID & TREADY;
  assign busy    = (state != IDLE);
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    beat_err = (TDATA != exp_data) | (TDEST != cfg_dest) | (TID != '0);
    len_sat  = (&beat_cnt) ? beat_cnt : beat_cnt + CNT_WIDTH'(1);
    len_err  = (len_sat != cfg_expected_beats);
    pkt_fail = err | beat_err | len_err;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (beat) next_state = TLAST ? REPORT : RECV;
      RECV:    if (beat && TLAST) next_state = REPORT;
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      TREADY <= 1'b0;
      lfsr   <= STALL_SEED;
    end else begin
      state  <= next_state;
      // Ready is decided from the registered LFSR, so no input reaches TREADY combinationally.
      TREADY <= (next_state != REPORT) & (~cfg_stall_en | lfsr[0]);
      if (cfg_stall_en) lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_cnt  <= '0;
      exp_data  <= '0;
      err       <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
      last_len  <= '0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      pkt_ok   <= 1'b0;
      if (beat && TLAST) begin
        pkt_done  <= 1'b1;
        pkt_ok    <= ~pkt_fail;
        beat_cnt  <= '0;
        exp_data  <= '0;
        err       <= 1'b0;
        last_len  <= len_sat;
        pkt_count <= pkt_count + 16'd1;
        if (pkt_fail && !(&err_count)) err_count <= err_count + 16'd1;
      end else if (beat) begin
        beat_cnt <= len_sat;
        exp_data <= exp_data + STREAM_DATA_WIDTH'(1);
        err      <= err | beat_err;
      end
      // Clear overrides a same-cycle packet update but leaves the result pulse intact.
      if (cfg_clear) begin
        last_len  <= '0;
        pkt_count <= '0;
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_pkt_checker.sv
// Directed bench for axi_stream_pkt_checker: good, corrupted, short, stalled, reset-aborted
// and cleared packets, each checked against hand-computed results.
module tb_axi_stream_pkt_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] TDATA = '0;
  logic        TLAST = 1'b0;
  logic [1:0]  TID = '0;
  logic [1:0]  TDEST = '0;
  logic        TVALID = 1'b0;
  logic        TREADY;
  logic [23:0] cfg_expected_beats = '0;
  logic [1:0]  cfg_dest = '0;
  logic        cfg_stall_en = 1'b0;
  logic        cfg_clear = 1'b0;
  logic        pkt_done;
  logic        pkt_ok;
  logic [23:0] last_len;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int stalls   = 0;

  localparam int BEAT_BUDGET = 60;

  always #5 clock = ~clock;

  axi_stream_pkt_checker dut (
    .clock(clock), .reset(reset),
    .TDATA(TDATA), .TLAST(TLAST), .TID(TID), .TDEST(TDEST),
    .TVALID(TVALID), .TREADY(TREADY),
    .cfg_expected_beats(cfg_expected_beats), .cfg_dest(cfg_dest),
    .cfg_stall_en(cfg_stall_en), .cfg_clear(cfg_clear),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .last_len(last_len),
    .pkt_count(pkt_count), .err_count(err_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Called #1 after an edge; returns #1 after the edge that accepted the beat.
  task automatic send_beat(input logic [31:0] data, input logic last, input logic [1:0] dest,
                           input logic [1:0] id, input logic clr);
    logic got;
    int   waited;
    TDATA  = data;
    TLAST  = last;
    TDEST  = dest;
    TID    = id;
    TVALID = 1'b1;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < BEAT_BUDGET) begin
      got       = TREADY;
      cfg_clear = clr & got;
      if (!got) stalls++;
      @(posedge clock);
      #1;
      cfg_clear = 1'b0;
      waited++;
    end
    if (!got) chk("accept_timeout", 32'(waited), 32'(BEAT_BUDGET + 1));
  endtask

  // n beats of 0..n-1 with TLAST on the final one; beat bad_idx gets the override fields.
  task automatic send_pkt(input int n, input int bad_idx, input logic [31:0] bad_data,
                          input logic [1:0] bad_dest, input logic [1:0] bad_id, input logic clr);
    for (int i = 0; i < n; i++) begin
      if (i == bad_idx) send_beat(bad_data, i == n - 1, bad_dest, bad_id, clr && (i == n - 1));
      else send_beat(32'(i), i == n - 1, cfg_dest, 2'd0, clr && (i == n - 1));
    end
    TVALID = 1'b0;
    TLAST  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic ok, input logic [23:0] len,
                            input logic [15:0] pc, input logic [15:0] ec);
    chk({tag, ".pkt_done"}, 32'(pkt_done), 32'd1);
    chk({tag, ".pkt_ok"}, 32'(pkt_ok), 32'(ok));
    chk({tag, ".last_len"}, 32'(last_len), 32'(len));
    chk({tag, ".pkt_count"}, 32'(pkt_count), 32'(pc));
    chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
  endtask

  initial begin
    cfg_expected_beats = 24'd4;
    cfg_dest           = 2'd1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst.tready", 32'(TREADY), 32'd0);
    chk("rst.pkt_done", 32'(pkt_done), 32'd0);
    chk("rst.pkt_count", 32'(pkt_count), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst.first_tready", 32'(TREADY), 32'd1);

    // 1: good 4-beat packet
    send_pkt(4, -1, 32'd0, 2'd0, 2'd0, 1'b0);
    chk("t1.busy_report", 32'(busy), 32'd1);
    chk("t1.tready_report", 32'(TREADY), 32'd0);
    chk_result("t1", 1'b1, 24'd4, 16'd1, 16'd0);
    @(posedge clock);
    #1;
    chk("t1.done_drop", 32'(pkt_done), 32'd0);
    chk("t1.idle", 32'(busy), 32'd0);

    // 2: beat 2 payload corrupted
    send_pkt(4, 2, 32'h7, 2'd1, 2'd0, 1'b0);
    chk_result("t2", 1'b0, 24'd4, 16'd2, 16'd1);

    // 3: short packet, TLAST on index 2
    send_pkt(3, -1, 32'd0, 2'd0, 2'd0, 1'b0);
    chk_result("t3", 1'b0, 24'd3, 16'd3, 16'd2);

    // TID nonzero on beat 1, then wrong TDEST on beat 0
    send_pkt(4, 1, 32'd1, 2'd1, 2'd1, 1'b0);
    chk_result("tid", 1'b0, 24'd4, 16'd4, 16'd3);
    send_pkt(4, 0, 32'd0, 2'd2, 2'd0, 1'b0);
    chk_result("tdest", 1'b0, 24'd4, 16'd5, 16'd4);

    // 4: 64-beat packet under LFSR backpressure
    cfg_expected_beats = 24'd64;
    cfg_stall_en       = 1'b1;
    stalls             = 0;
    send_pkt(64, -1, 32'd0, 2'd0, 2'd0, 1'b0);
    chk_result("t4", 1'b1, 24'd64, 16'd6, 16'd4);
    chk("t4.stall_seen", 32'(stalls != 0), 32'd1);
    cfg_stall_en = 1'b0;
    @(posedge clock);
    #1;

    // zero expected length fails even a clean single beat
    cfg_expected_beats = 24'd0;
    send_pkt(1, -1, 32'd0, 2'd0, 2'd0, 1'b0);
    chk_result("exp0", 1'b0, 24'd1, 16'd7, 16'd5);

    // 5: reset after 5 of 8 beats
    cfg_expected_beats = 24'd8;
    for (int i = 0; i < 5; i++) send_beat(32'(i), 1'b0, cfg_dest, 2'd0, 1'b0);
    TVALID = 1'b0;
    reset  = 1'b1;
    #1;
    chk("t5.tready", 32'(TREADY), 32'd0);
    chk("t5.pkt_count", 32'(pkt_count), 32'd0);
    chk("t5.err_count", 32'(err_count), 32'd0);
    chk("t5.busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    send_pkt(8, -1, 32'd0, 2'd0, 2'd0, 1'b0);
    chk_result("t5", 1'b1, 24'd8, 16'd1, 16'd0);

    // 6: clear on the TLAST cycle of a short (bad) packet
    cfg_expected_beats = 24'd4;
    send_pkt(2, -1, 32'd0, 2'd0, 2'd0, 1'b1);
    chk_result("t6", 1'b0, 24'd0, 16'd0, 16'd0);
    cfg_expected_beats = 24'd1;
    send_pkt(1, -1, 32'd0, 2'd0, 2'd0, 1'b0);
    chk_result("t6b", 1'b1, 24'd1, 16'd1, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
